ide_sector_xfer: RTL and testbench

//   Host-side sequencer for the IDE disk port. Sits directly upstream of the ide device.
//   On a start request it programs the address registers and issues a read (0x20) or

---
 rtl/ide_sector_xfer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ide_sector_xfer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ide_sector_xfer.sv
`timescale 1ns/1ps
// Host-side IDE sector sequencer: programs the LBA registers, issues a read/write
// command, streams 512 bytes through data register 0, then polls status until idle.
module ide_sector_xfer #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        dir,
    input  logic [23:0] lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        ide_ce_n,
    output logic        ide_oe_n,
    output logic        ide_we_n,
    output logic [2:0]  ide_address,
    output logic [7:0]  ide_data_out,
    input  logic [7:0]  ide_data_in
);

    localparam int unsigned STRB_W = $clog2(STROBE_CYCLES + 1);
    localparam int unsigned SETL_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W  = 10;
    localparam logic [CNT_W-1:0] SECTOR_BYTES = CNT_W'(512);
    localparam logic [CNT_W-1:0] LAST_BYTE    = CNT_W'(511);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LBA0, ST_LBA1, ST_LBA2, ST_CMD,
        ST_SETTLE, ST_XFER, ST_POLL, ST_DONE
    } state_e;

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_e;

    state_e             state_q, state_d;
    phase_e             ph_q, ph_d;
    logic [STRB_W-1:0]  strb_cnt_q, strb_cnt_d;
    logic [SETL_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               dir_q, dir_d;
    logic [23:0]        lba_q, lba_d;
    logic [7:0]         cap_q, cap_d;
    logic               acc_wr_q, acc_wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_ready_q, wr_ready_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic [2:0]         addr_q, addr_d;
    logic [7:0]         dout_q, dout_d;

    logic               acc_last;
    logic               acc_go;
    logic               acc_go_wr;
    logic [2:0]         acc_go_addr;
    logic [7:0]         acc_go_data;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_IDLE;
            ph_q         <= PH_IDLE;
            strb_cnt_q   <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            dir_q        <= 1'b0;
            lba_q        <= '0;
            cap_q        <= '0;
            acc_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            addr_q       <= '0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            strb_cnt_q   <= strb_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            dir_q        <= dir_d;
            lba_q        <= lba_d;
            cap_q        <= cap_d;
            acc_wr_q     <= acc_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wr_ready_q   <= wr_ready_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        strb_cnt_d   = strb_cnt_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        dir_d        = dir_q;
        lba_d        = lba_q;
        cap_d        = cap_q;
        acc_wr_d     = acc_wr_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        wr_ready_d   = 1'b0;
        addr_d       = addr_q;
        dout_d       = dout_q;
        acc_go       = 1'b0;
        acc_go_wr    = 1'b0;
        acc_go_addr  = '0;
        acc_go_data  = '0;
        acc_last     = (ph_q == PH_HOLD);

        // Bus access engine: SETUP -> STROBE x N -> HOLD -> (ce_n high gap)
        unique case (ph_q)
            PH_SETUP: begin
                ph_d       = PH_STROBE;
                strb_cnt_d = '0;
            end
            PH_STROBE: begin
                if (strb_cnt_q == STRB_W'(STROBE_CYCLES - 1)) begin
                    ph_d = PH_HOLD;
                    if (!acc_wr_q) begin
                        cap_d = ide_data_in;
                    end
                end else begin
                    strb_cnt_d = strb_cnt_q + STRB_W'(1);
                end
            end
            PH_HOLD: ph_d = PH_IDLE;
            default: ;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                if (start) begin
                    dir_d   = dir;
                    lba_d   = lba;
                    state_d = ST_LBA0;
                end
            end
            ST_LBA0: begin
                if (ph_q == PH_IDLE) begin
                    acc_go = 1'b1; acc_go_wr = 1'b1; acc_go_addr = 3'd3; acc_go_data = lba_q[7:0];
                end else if (acc_last) begin
                    state_d = ST_LBA1;
                end
            end
            ST_LBA1: begin
                if (ph_q == PH_IDLE) begin
                    acc_go = 1'b1; acc_go_wr = 1'b1; acc_go_addr = 3'd4; acc_go_data = lba_q[15:8];
                end else if (acc_last) begin
                    state_d = ST_LBA2;
                end
            end
            ST_LBA2: begin
                if (ph_q == PH_IDLE) begin
                    acc_go = 1'b1; acc_go_wr = 1'b1; acc_go_addr = 3'd5; acc_go_data = lba_q[23:16];
                end else if (acc_last) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ph_q == PH_IDLE) begin
                    acc_go      = 1'b1;
                    acc_go_wr   = 1'b1;
                    acc_go_addr = 3'd7;
                    acc_go_data = dir_q ? 8'h30 : 8'h20;
                end else if (acc_last) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETL_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_XFER;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETL_W'(1);
                end
            end
            ST_XFER: begin
                if (acc_last) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end
                if (!dir_q) begin
                    // Read: one byte parked in rd_data until the consumer takes it
                    if (acc_last) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = cap_q;
                    end else if (rd_valid_q) begin
                        if (rd_ready) begin
                            rd_valid_d = 1'b0;
                            if (byte_cnt_q == SECTOR_BYTES) begin
                                state_d   = ST_POLL;
                                tmo_cnt_d = '0;
                            end
                        end
                    end else if (ph_q == PH_IDLE) begin
                        acc_go = 1'b1; acc_go_addr = 3'd0;
                    end
                end else begin
                    if (acc_last) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d   = ST_POLL;
                            tmo_cnt_d = '0;
                        end
                    end else if ((ph_q == PH_IDLE) && wr_valid) begin
                        wr_ready_d  = 1'b1;
                        acc_go      = 1'b1;
                        acc_go_wr   = 1'b1;
                        acc_go_addr = 3'd0;
                        acc_go_data = wr_data;
                    end
                end
            end
            ST_POLL: begin
                if (acc_last && !cap_q[3]) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    ph_d    = PH_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (ph_q == PH_IDLE) begin
                        acc_go = 1'b1; acc_go_addr = 3'd7;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ph_d    = PH_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (acc_go) begin
            ph_d     = PH_SETUP;
            acc_wr_d = acc_go_wr;
            addr_d   = acc_go_addr;
            if (acc_go_wr) begin
                dout_d = acc_go_data;
            end
        end

        busy_d = (state_d != ST_IDLE);
        ce_n_d = (ph_d == PH_IDLE);
        oe_n_d = !((ph_d == PH_STROBE) && !acc_wr_d);
        we_n_d = !((ph_d == PH_STROBE) && acc_wr_d);
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign wr_ready     = wr_ready_q;
    assign ide_ce_n     = ce_n_q;
    assign ide_oe_n     = oe_n_q;
    assign ide_we_n     = we_n_q;
    assign ide_address  = addr_q;
    assign ide_data_out = dout_q;

endmodule

// File: tb/tb_ide_sector_xfer.sv
`timescale 1ns/1ps
// Bench for ide_sector_xfer: behavioural IDE device plus scoreboard queues for
// bus writes, read bytes and done/error results.
module tb_ide_sector_xfer;

    localparam int unsigned STROBE_CYCLES  = 2;
    localparam int unsigned SETTLE_CYCLES  = 4;
    localparam int unsigned TIMEOUT_CYCLES = 4096;
    localparam int          WAIT_LIMIT     = 20000;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        dir;
    logic [23:0] lba;
    logic        busy, done, error;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        ide_ce_n, ide_oe_n, ide_we_n;
    logic [2:0]  ide_address;
    logic [7:0]  ide_data_out;
    logic [7:0]  ide_data_in;

    always #5 clk = ~clk;

    ide_sector_xfer #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .dir(dir), .lba(lba),
        .busy(busy), .done(done), .error(error),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ide_ce_n(ide_ce_n), .ide_oe_n(ide_oe_n), .ide_we_n(ide_we_n),
        .ide_address(ide_address), .ide_data_out(ide_data_out), .ide_data_in(ide_data_in)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_wr_rdy = 0;
    int n_rd_hs  = 0;
    int last_hs_cyc = 0;
    int done_cyc    = 0;
    int rd_duty     = 100;

    logic [10:0] exp_bus[$];
    logic [7:0]  exp_rd[$];
    bit          exp_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_byte(input int a);
        return 8'((a * 37) ^ (a >> 5) ^ 8'h5A);
    endfunction

    always @(posedge clk) cyc++;

    // Device model: register file, sector memory, status busy bit 3
    logic [7:0]  mem [0:8191];
    bit          mem_loaded = 1'b0;
    logic [7:0]  dreg3 = 8'h00, dreg4 = 8'h00;
    logic [12:0] dev_ptr = '0;
    int          dev_dcnt = 0;
    int          dev_poll_left = 0;
    bit          dev_active = 1'b0;
    bit          dev_stuck = 1'b0;
    logic        dev_status;
    logic        prev_we_n = 1'b1, prev_oe_n = 1'b1, prev_ce_n = 1'b1;
    int          strb_len = 0;

    assign dev_status  = dev_active && ((dev_dcnt < 512) || (dev_poll_left > 0) || dev_stuck);
    assign ide_data_in = (ide_address == 3'd7) ? {4'b0000, dev_status, 3'b000} :
                         (ide_address == 3'd0) ? mem[dev_ptr] : 8'h00;

    always @(negedge clk) begin
        logic [10:0] e;
        if (!mem_loaded) begin
            for (int i = 0; i < 8192; i++) mem[i] = img_byte(i);
            mem_loaded = 1'b1;
        end
        if (!ide_ce_n && !ide_we_n && prev_we_n) begin
            if (exp_bus.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL bus_write: got reg%0d=0x%02h expected no write", ide_address, ide_data_out);
            end else begin
                e = exp_bus.pop_front();
                check("bus_write", {ide_address, ide_data_out}, e);
            end
            case (ide_address)
                3'd0: begin mem[dev_ptr] = ide_data_out; dev_ptr++; dev_dcnt++; end
                3'd3: dreg3 = ide_data_out;
                3'd4: dreg4 = ide_data_out;
                3'd7: begin
                    dev_ptr = {dreg4[4:0], dreg3};
                    dev_dcnt = 0; dev_poll_left = 2; dev_active = 1'b1;
                end
                default: ;
            endcase
        end
        if (!ide_ce_n && ide_oe_n && !prev_oe_n) begin
            if (ide_address == 3'd0) begin dev_ptr++; dev_dcnt++; end
            if (ide_address == 3'd7 && dev_dcnt >= 512 && dev_poll_left > 0) dev_poll_left--;
        end
        // Strobe shape: setup clk with ce_n low before, exact width when ended normally
        if (!ide_oe_n || !ide_we_n) begin
            if (strb_len == 0) check("setup_ce_n", prev_ce_n, 1'b0);
            strb_len++;
        end else begin
            if (strb_len != 0 && !ide_ce_n) check("strobe_len", strb_len, STROBE_CYCLES);
            strb_len = 0;
        end
        prev_we_n = ide_we_n; prev_oe_n = ide_oe_n; prev_ce_n = ide_ce_n;
    end

    // Read-stream consumer and monitor
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rd_ready = ($urandom_range(0, 99) < rd_duty);
        end
    end

    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            n_rd_hs++;
            last_hs_cyc = cyc;
            if (exp_rd.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_byte: got 0x%02h expected no byte", rd_data);
            end else begin
                check("rd_byte", rd_data, exp_rd.pop_front());
            end
        end else if (rd_valid && !rd_ready) begin
            check("stall_ce_n", ide_ce_n, 1'b1);
        end
        if (wr_ready) n_wr_rdy++;
    end

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: got done=1 error=%0d expected no done", error);
            end else begin
                check("done_error", error, exp_done.pop_front());
            end
        end
    end

    task automatic expect_setup(input bit d, input logic [23:0] a);
        exp_bus.push_back({3'd3, a[7:0]});
        exp_bus.push_back({3'd4, a[15:8]});
        exp_bus.push_back({3'd5, a[23:16]});
        exp_bus.push_back({3'd7, (d ? 8'h30 : 8'h20)});
    endtask

    task automatic do_start(input bit d, input logic [23:0] a);
        @(posedge clk); #1;
        start = 1'b1; dir = d; lba = a;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int base;
        int c;
        base = n_done;
        c = 0;
        while (n_done == base && c < WAIT_LIMIT) begin
            @(posedge clk); c++;
        end
        if (n_done == base) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no done expected done within %0d clks", name, WAIT_LIMIT);
        end else begin
            #1;
            check({name, "_busy_drop"}, busy, 1'b0);
        end
    endtask

    task automatic write_stream(input int n, input int stop_at);
        int i;
        int guard;
        i = 0; guard = 0;
        wr_valid = 1'b1; wr_data = 8'h00;
        while (i < n && i < stop_at && guard < WAIT_LIMIT) begin
            @(posedge clk); #1; guard++;
            if (wr_ready) begin
                i++;
                wr_data = 8'(i);
            end
        end
        wr_valid = 1'b0;
        if (guard >= WAIT_LIMIT) begin
            n_checks++; n_fail++;
            $display("FAIL wr_stream_timeout: got %0d bytes expected %0d", i, n);
        end
    endtask

    task automatic run_read(input string name, input logic [23:0] a, input bit img, input bit err);
        int wr0;
        wr0 = n_wr_rdy;
        expect_setup(1'b0, a);
        for (int i = 0; i < 512; i++)
            exp_rd.push_back(img ? img_byte(int'(a[12:0]) + i) : 8'(i));
        exp_done.push_back(err);
        do_start(1'b0, a);
        wait_done(name);
        check({name, "_no_wr_ready"}, n_wr_rdy - wr0, 0);
        check({name, "_rd_left"}, exp_rd.size(), 0);
        check({name, "_dev_bytes"}, dev_dcnt, 512);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test expected completion before 900us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        int bad;
        int done0;
        int hs0;
        int c;
        arst = 1'b0; start = 1'b0; dir = 1'b0; lba = '0;
        wr_data = 8'h00; wr_valid = 1'b0;
        #2 arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_ce_n", ide_ce_n, 1'b1);
        check("rst_oe_n", ide_oe_n, 1'b1);
        check("rst_we_n", ide_we_n, 1'b1);
        check("rst_address", ide_address, 3'd0);
        check("rst_data_out", ide_data_out, 8'h00);
        arst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: sector read from image
        run_read("read_200", 24'h000200, 1'b1, 1'b0);
        check("read_200_status3", dev_status, 1'b0);
        check("read_200_bus_left", exp_bus.size(), 0);

        // 2: sector write of 0..255 twice, then read back
        wr0 = n_wr_rdy;
        expect_setup(1'b1, 24'h001000);
        for (int i = 0; i < 512; i++) exp_bus.push_back({3'd0, 8'(i)});
        exp_done.push_back(1'b0);
        do_start(1'b1, 24'h001000);
        write_stream(512, 512);
        wait_done("write_1000");
        check("write_wr_ready_cnt", n_wr_rdy - wr0, 512);
        check("write_bus_left", exp_bus.size(), 0);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[13'h1000 + 13'(i)] !== 8'(i)) bad++;
        check("write_mem_image", bad, 0);
        run_read("readback_1000", 24'h001000, 1'b0, 1'b0);

        // 3: read under consumer backpressure
        rd_duty = 30;
        run_read("bp_read_a00", 24'h000A00, 1'b1, 1'b0);
        rd_duty = 100;

        // 4: device never clears busy -> timeout
        dev_stuck = 1'b1;
        run_read("timeout_400", 24'h000400, 1'b1, 1'b1);
        check("timeout_window", ((done_cyc - last_hs_cyc) >= int'(TIMEOUT_CYCLES)) &&
                                ((done_cyc - last_hs_cyc) <= int'(TIMEOUT_CYCLES) + 2), 1'b1);
        dev_stuck = 1'b0;

        // 5: second start mid-transfer is ignored
        done0 = n_done;
        hs0 = n_rd_hs;
        expect_setup(1'b0, 24'h000600);
        for (int i = 0; i < 512; i++) exp_rd.push_back(img_byte(16'h0600 + i));
        exp_done.push_back(1'b0);
        do_start(1'b0, 24'h000600);
        c = 0;
        while (n_rd_hs < hs0 + 50 && c < WAIT_LIMIT) begin @(posedge clk); c++; end
        check("busy_start_reached_50", n_rd_hs >= hs0 + 50, 1'b1);
        #1;
        start = 1'b1; dir = 1'b1; lba = 24'h0ABCDE;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start");
        repeat (20) @(posedge clk);
        check("busy_start_one_done", n_done - done0, 1);
        check("busy_start_rd_left", exp_rd.size(), 0);

        // 6: reset mid-write, then a clean transfer
        expect_setup(1'b1, 24'h000800);
        for (int i = 0; i < 512; i++) exp_bus.push_back({3'd0, 8'(i)});
        do_start(1'b1, 24'h000800);
        write_stream(512, 100);
        arst = 1'b1;
        exp_bus.delete();
        done0 = n_done;
        @(posedge clk); #1;
        check("arst_ce_n", ide_ce_n, 1'b1);
        check("arst_oe_n", ide_oe_n, 1'b1);
        check("arst_we_n", ide_we_n, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        arst = 1'b0;
        repeat (20) @(posedge clk);
        check("arst_no_done", n_done - done0, 0);
        run_read("post_arst_c00", 24'h000C00, 1'b1, 1'b0);
        check("final_bus_left", exp_bus.size(), 0);
        check("final_done_left", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
